// File: rtl/s3g_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// s3g_pkg : shared constants, framer state encoding and CRC-8 byte update
// Rev 1.0
// ----------------------------------------------------------------------------
package s3g_pkg;

   localparam logic [7:0] START_BYTE = 8'hD5;
   localparam logic [7:0] CRC_POLY   = 8'h8C;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LEN     = 3'd1,
      ST_PAYLOAD = 3'd2,
      ST_CRC     = 3'd3,
      ST_HOLD    = 3'd4
   } fr_state_t;

   // Maxim CRC-8, reflected form: LSB-first shift, no final XOR
   function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] c;
      c = crc ^ data;
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
      end
      return c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/s3g_rx_chan.sv
`default_nettype none
// ----------------------------------------------------------------------------
// s3g_rx_chan : one channel's framer, payload buffer and inter-byte timeout
// Rev 1.0
// ----------------------------------------------------------------------------
module s3g_rx_chan
   import s3g_pkg::*;
#(
   parameter int MAX_LEN        = 32,
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int LEN_W          = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       i_rx_byte,
   input  logic             i_rx_done,
   input  logic             i_take,
   input  logic [LEN_W-1:0] i_rd_addr,
   output logic             o_hold,
   output logic [7:0]       o_len,
   output logic [7:0]       o_buf0,
   output logic [7:0]       o_rd_byte,
   output logic             o_len_err,
   output logic             o_timeout,
   output logic             o_crc_err,
   output logic             o_hold_drop
);

   localparam int              TO_W      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] c_to_last = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]      c_max_len = 8'(MAX_LEN);

   fr_state_t       r_state, w_next;
   logic [7:0]      r_len, r_cnt, r_crc;
   logic [TO_W-1:0] r_idle;
   logic [7:0]      r_mem [MAX_LEN];
   logic            w_wr, w_active, w_to;

   assign w_active = (r_state == ST_LEN) || (r_state == ST_PAYLOAD) || (r_state == ST_CRC);
   assign w_to     = w_active && !i_rx_done && (r_idle == c_to_last);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      w_wr        = 1'b0;
      o_len_err   = 1'b0;
      o_timeout   = w_to;
      o_crc_err   = 1'b0;
      o_hold_drop = 1'b0;
      case (r_state)
         ST_IDLE: if (i_rx_done && i_rx_byte == START_BYTE) w_next = ST_LEN;
         ST_LEN: if (i_rx_done) begin
            if (i_rx_byte == 8'd0 || i_rx_byte > c_max_len) begin
               w_next    = ST_IDLE;
               o_len_err = 1'b1;
            end else begin
               w_next = ST_PAYLOAD;
            end
         end
         ST_PAYLOAD: if (i_rx_done) begin
            w_wr = 1'b1;
            if (r_cnt == r_len - 8'd1) w_next = ST_CRC;
         end
         ST_CRC: if (i_rx_done) begin
            if (i_rx_byte == r_crc) begin
               w_next = ST_HOLD;
            end else begin
               w_next    = ST_IDLE;
               o_crc_err = 1'b1;
            end
         end
         ST_HOLD: begin
            o_hold_drop = i_rx_done;
            if (i_take) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
      if (w_to) w_next = ST_IDLE;
   end

   // Idle counter only runs while a frame is open; any byte restarts it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_len  <= '0;
         r_cnt  <= '0;
         r_crc  <= '0;
         r_idle <= '0;
      end else begin
         if (!w_active || i_rx_done) r_idle <= '0;
         else                        r_idle <= r_idle + 1'b1;
         if (r_state == ST_LEN && i_rx_done) begin
            r_len <= i_rx_byte;
            r_cnt <= '0;
            r_crc <= '0;
         end
         if (w_wr) begin
            r_cnt <= r_cnt + 8'd1;
            r_crc <= crc8_byte(r_crc, i_rx_byte);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_cnt[LEN_W-1:0]] <= i_rx_byte;
   end

   assign o_hold    = (r_state == ST_HOLD);
   assign o_len     = r_len;
   assign o_buf0    = r_mem[0];
   assign o_rd_byte = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/s3g_rx_multi.sv
`default_nettype none
// ----------------------------------------------------------------------------
// s3g_rx_multi : multi-channel packet receiver with round-robin output arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
module s3g_rx_multi
   import s3g_pkg::*;
#(
   parameter  int NUM_CH         = 2,
   parameter  int MAX_LEN        = 32,
   parameter  int TIMEOUT_CYCLES = 50000,
   localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int LEN_W          = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [8*NUM_CH-1:0] rx_data,
   input  logic [NUM_CH-1:0]   rx_done,
   output logic                pkt_valid,
   input  logic                pkt_ready,
   output logic [CH_W-1:0]     pkt_ch,
   output logic [7:0]          pkt_len,
   output logic [7:0]          buf0,
   input  logic [LEN_W-1:0]    rd_addr,
   output logic [7:0]          rd_data,
   output logic [15:0]         crc_err_cnt,
   output logic [15:0]         drop_cnt
);

   logic [NUM_CH-1:0] w_hold, w_take, w_len_err, w_timeout, w_crc_err, w_hold_drop;
   logic [7:0]        w_len [NUM_CH];
   logic [7:0]        w_buf0 [NUM_CH];
   logic [7:0]        w_rd_byte [NUM_CH];
   logic              r_valid, w_found, w_grant;
   logic [CH_W-1:0]   r_ch, r_ptr, w_gnt_ch, w_sel;
   logic [7:0]        r_len, r_buf0, r_rd_data;
   logic [15:0]       r_crc_cnt, r_drop_cnt;
   logic [2:0]        w_crc_n, w_drop_n;

   function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [2:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {14'd0, b};
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

   generate
      for (genvar n = 0; n < NUM_CH; n++) begin : g_chan
         assign w_take[n] = r_valid && pkt_ready && (r_ch == CH_W'(n));
         s3g_rx_chan #(
            .MAX_LEN        (MAX_LEN),
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
            .LEN_W          (LEN_W)
         ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .i_rx_byte   (rx_data[8*n +: 8]),
            .i_rx_done   (rx_done[n]),
            .i_take      (w_take[n]),
            .i_rd_addr   (rd_addr),
            .o_hold      (w_hold[n]),
            .o_len       (w_len[n]),
            .o_buf0      (w_buf0[n]),
            .o_rd_byte   (w_rd_byte[n]),
            .o_len_err   (w_len_err[n]),
            .o_timeout   (w_timeout[n]),
            .o_crc_err   (w_crc_err[n]),
            .o_hold_drop (w_hold_drop[n])
         );
      end
   endgenerate

   // Scan backwards so the first holder at or after r_ptr wins
   always_comb begin
      w_found  = 1'b0;
      w_gnt_ch = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (w_hold[CH_W'((int'(r_ptr) + i) % NUM_CH)]) begin
            w_found  = 1'b1;
            w_gnt_ch = CH_W'((int'(r_ptr) + i) % NUM_CH);
         end
      end
   end

   assign w_grant = !r_valid && w_found;
   assign w_sel   = w_grant ? w_gnt_ch : r_ch;

   // Drop sources within one channel are mutually exclusive, so OR then add
   always_comb begin
      w_crc_n  = '0;
      w_drop_n = '0;
      for (int n = 0; n < NUM_CH; n++) begin
         w_crc_n  = w_crc_n + {2'b00, w_crc_err[n]};
         w_drop_n = w_drop_n + {2'b00, w_len_err[n] | w_timeout[n] | w_hold_drop[n]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid    <= 1'b0;
         r_ch       <= '0;
         r_ptr      <= '0;
         r_len      <= '0;
         r_buf0     <= '0;
         r_rd_data  <= '0;
         r_crc_cnt  <= '0;
         r_drop_cnt <= '0;
      end else begin
         r_rd_data <= w_rd_byte[w_sel];
         if (w_grant) begin
            r_valid <= 1'b1;
            r_ch    <= w_gnt_ch;
            r_ptr   <= (w_gnt_ch == CH_W'(NUM_CH - 1)) ? '0 : w_gnt_ch + 1'b1;
            r_len   <= w_len[w_gnt_ch];
            r_buf0  <= w_buf0[w_gnt_ch];
         end else if (r_valid && pkt_ready) begin
            r_valid <= 1'b0;
         end
         r_crc_cnt  <= sat_add(r_crc_cnt, w_crc_n);
         r_drop_cnt <= sat_add(r_drop_cnt, w_drop_n);
      end
   end

   assign pkt_valid   = r_valid;
   assign pkt_ch      = r_ch;
   assign pkt_len     = r_len;
   assign buf0        = r_buf0;
   assign rd_data     = r_rd_data;
   assign crc_err_cnt = r_crc_cnt;
   assign drop_cnt    = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_s3g_rx_multi.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_s3g_rx_multi : directed scenarios plus random traffic against a packet model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_s3g_rx_multi;

   localparam int NUM_CH         = 3;
   localparam int MAX_LEN        = 32;
   localparam int TIMEOUT_CYCLES = 300;
   localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int LEN_W          = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int M_IDLE = 0, M_LEN = 1, M_PAY = 2, M_CRC = 3, M_HOLD = 4;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic [8*NUM_CH-1:0] rx_data = '0;
   logic [NUM_CH-1:0]   rx_done = '0;
   logic                pkt_valid;
   logic                pkt_ready = 1'b0;
   logic [CH_W-1:0]     pkt_ch;
   logic [7:0]          pkt_len, buf0, rd_data;
   logic [LEN_W-1:0]    rd_addr = '0;
   logic [15:0]         crc_err_cnt, drop_cnt;

   int n_total = 0;
   int n_bad   = 0;

   s3g_rx_multi #(
      .NUM_CH         (NUM_CH),
      .MAX_LEN        (MAX_LEN),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_data     (rx_data),
      .rx_done     (rx_done),
      .pkt_valid   (pkt_valid),
      .pkt_ready   (pkt_ready),
      .pkt_ch      (pkt_ch),
      .pkt_len     (pkt_len),
      .buf0        (buf0),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .crc_err_cnt (crc_err_cnt),
      .drop_cnt    (drop_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: per-channel framing phase plus collected payload queue
   int         m_mode [NUM_CH];
   int         m_len  [NUM_CH];
   int         m_sil  [NUM_CH];
   logic [7:0] m_pl   [NUM_CH][$];
   logic [7:0] txq    [NUM_CH][$];
   bit         m_valid;
   int         m_ch, m_ptr, m_crc, m_drop, m_addr;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] ref_crc(input logic [7:0] q[$]);
      logic [7:0] c = 8'h00;
      foreach (q[k]) begin
         c = c ^ q[k];
         repeat (8) c = c[0] ? ((c >> 1) ^ 8'h8C) : (c >> 1);
      end
      return c;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         m_mode[c] = M_IDLE;
         m_len[c]  = 0;
         m_sil[c]  = 0;
         m_pl[c].delete();
      end
      m_valid = 1'b0;
      m_ch = 0; m_ptr = 0; m_crc = 0; m_drop = 0; m_addr = 0;
   endtask

   task automatic model_edge();
      int rel, pre;
      bit d;
      logic [7:0] b;
      rel = -1;
      if (rst) begin
         model_reset();
         return;
      end
      if (m_valid && pkt_ready) begin
         rel = m_ch;
         m_valid = 1'b0;
      end else if (!m_valid) begin
         for (int i = 0; i < NUM_CH; i++) begin
            int c;
            c = (m_ptr + i) % NUM_CH;
            if (m_mode[c] == M_HOLD) begin
               m_valid = 1'b1;
               m_ch    = c;
               m_ptr   = (c + 1) % NUM_CH;
               break;
            end
         end
      end
      for (int c = 0; c < NUM_CH; c++) begin
         d   = rx_done[c];
         b   = rx_data[8*c +: 8];
         pre = m_mode[c];
         if (d) m_sil[c] = 0;
         case (pre)
            M_IDLE: if (d && b == 8'hD5) m_mode[c] = M_LEN;
            M_LEN: if (d) begin
               if (b == 0 || b > MAX_LEN) begin
                  m_mode[c] = M_IDLE;
                  if (m_drop < 65535) m_drop++;
               end else begin
                  m_len[c] = b;
                  m_pl[c].delete();
                  m_mode[c] = M_PAY;
               end
            end
            M_PAY: if (d) begin
               m_pl[c].push_back(b);
               if (m_pl[c].size() == m_len[c]) m_mode[c] = M_CRC;
            end
            M_CRC: if (d) begin
               if (b == ref_crc(m_pl[c])) m_mode[c] = M_HOLD;
               else begin
                  m_mode[c] = M_IDLE;
                  if (m_crc < 65535) m_crc++;
               end
            end
            default: if (d && m_drop < 65535) m_drop++;
         endcase
         if (!d && (pre == M_LEN || pre == M_PAY || pre == M_CRC)) begin
            m_sil[c]++;
            if (m_sil[c] == TIMEOUT_CYCLES) begin
               m_mode[c] = M_IDLE;
               m_sil[c]  = 0;
               if (m_drop < 65535) m_drop++;
            end
         end
      end
      if (rel >= 0) m_mode[rel] = M_IDLE;
      m_addr = int'(rd_addr);
   endtask

   task automatic compare();
      chk("pkt_valid", pkt_valid, m_valid);
      if (m_valid) begin
         chk("pkt_ch", pkt_ch, m_ch);
         chk("pkt_len", pkt_len, m_pl[m_ch].size());
         chk("buf0", buf0, m_pl[m_ch][0]);
         if (m_addr < m_pl[m_ch].size()) chk("rd_data", rd_data, m_pl[m_ch][m_addr]);
      end
      chk("crc_err_cnt", crc_err_cnt, m_crc);
      chk("drop_cnt", drop_cnt, m_drop);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare();
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic tx(input int ch, input logic [7:0] b);
      rx_data[8*ch +: 8] = b;
      rx_done[ch] = 1'b1;
      step();
      rx_done[ch] = 1'b0;
   endtask

   task automatic tx2(input logic [7:0] b);
      rx_data[7:0]  = b;
      rx_data[15:8] = b;
      rx_done[1:0]  = 2'b11;
      step();
      rx_done[1:0]  = 2'b00;
   endtask

   task automatic good_pkt(input int ch);
      tx(ch, 8'hD5); tx(ch, 8'h01); tx(ch, 8'h42); tx(ch, 8'hFA);
   endtask

   task automatic do_reset();
      rx_done   = '0;
      pkt_ready = 1'b0;
      rst       = 1'b1;
      #1;
      model_reset();
      chk("rst_valid", pkt_valid, 0);
      chk("rst_ch", pkt_ch, 0);
      chk("rst_len", pkt_len, 0);
      chk("rst_buf0", buf0, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_crc_cnt", crc_err_cnt, 0);
      chk("rst_drop_cnt", drop_cnt, 0);
      step();
      rst = 1'b0;
   endtask

   task automatic gen_frame(input int c);
      int kind, len;
      logic [7:0] p[$];
      logic [7:0] cr;
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
         txq[c].push_back(8'($urandom));
      end else if (kind == 1) begin
         txq[c].push_back(8'hD5);
         txq[c].push_back(($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(MAX_LEN + 1, 255)));
      end else begin
         len = (kind == 2) ? MAX_LEN : $urandom_range(1, 6);
         txq[c].push_back(8'hD5);
         txq[c].push_back(8'(len));
         for (int k = 0; k < len; k++) begin
            p.push_back(8'($urandom));
            txq[c].push_back(p[k]);
         end
         cr = ref_crc(p);
         if (kind == 3) cr = cr ^ 8'(1 << $urandom_range(0, 7));
         txq[c].push_back(cr);
      end
   endtask

   initial begin
      logic [7:0] pay[$];
      #1;
      do_reset();

      // single good packet on ch0
      good_pkt(0);
      chk("good_not_yet", pkt_valid, 0);
      step();
      chk("good_valid", pkt_valid, 1);
      chk("good_ch", pkt_ch, 0);
      chk("good_len", pkt_len, 1);
      chk("good_buf0", buf0, 8'h42);
      chk("good_crc_cnt", crc_err_cnt, 0);
      pkt_ready = 1'b1;
      step();
      chk("good_released", pkt_valid, 0);

      // bad CRC then good packet
      do_reset();
      tx(0, 8'hD5); tx(0, 8'h01); tx(0, 8'h42); tx(0, 8'hFB);
      idle(2);
      chk("badcrc_valid", pkt_valid, 0);
      chk("badcrc_cnt", crc_err_cnt, 1);
      good_pkt(0);
      step();
      chk("badcrc_recover", pkt_valid, 1);
      pkt_ready = 1'b1;
      step();

      // ch0 and ch1 complete together with ready held high
      do_reset();
      pkt_ready = 1'b1;
      tx2(8'hD5); tx2(8'h01); tx2(8'h42); tx2(8'hFA);
      chk("both_t0", pkt_valid, 0);
      step();
      chk("both_t1_valid", pkt_valid, 1);
      chk("both_t1_ch", pkt_ch, 0);
      step();
      chk("both_gap", pkt_valid, 0);
      step();
      chk("both_t3_valid", pkt_valid, 1);
      chk("both_t3_ch", pkt_ch, 1);
      step();
      chk("both_done", pkt_valid, 0);

      // length errors: zero and MAX_LEN+1
      do_reset();
      tx(1, 8'hD5); tx(1, 8'h00); tx(1, 8'hD5); tx(1, 8'(MAX_LEN + 1));
      idle(3);
      chk("lenerr_drop", drop_cnt, 2);
      chk("lenerr_valid", pkt_valid, 0);

      // maximum length accepted, last byte readable
      do_reset();
      tx(2, 8'hD5); tx(2, 8'(MAX_LEN));
      for (int k = 0; k < MAX_LEN; k++) begin
         pay.push_back(8'($urandom));
         tx(2, pay[k]);
      end
      tx(2, ref_crc(pay));
      rd_addr = LEN_W'(MAX_LEN - 1);
      idle(2);
      chk("maxlen_valid", pkt_valid, 1);
      chk("maxlen_len", pkt_len, MAX_LEN);
      chk("maxlen_last", rd_data, pay[MAX_LEN-1]);
      rd_addr = '0;

      // inter-byte timeout boundary
      do_reset();
      tx(0, 8'hD5); tx(0, 8'h03); tx(0, 8'h11);
      idle(TIMEOUT_CYCLES - 1);
      chk("to_before", drop_cnt, 0);
      idle(1);
      chk("to_fired", drop_cnt, 1);
      good_pkt(0);
      step();
      chk("to_recover_valid", pkt_valid, 1);
      chk("to_recover_len", pkt_len, 1);

      // HOLD overrun, buffer read, then reset mid-payload
      do_reset();
      good_pkt(0);
      step();
      tx(0, 8'h33); tx(0, 8'h44);
      chk("hold_drop", drop_cnt, 2);
      chk("hold_valid", pkt_valid, 1);
      rd_addr = '0;
      step();
      chk("hold_rd0", rd_data, 8'h42);
      tx(1, 8'hD5); tx(1, 8'h03); tx(1, 8'h11);
      do_reset();
      good_pkt(1);
      step();
      chk("after_rst_valid", pkt_valid, 1);
      chk("after_rst_ch", pkt_ch, 1);
      pkt_ready = 1'b1;
      step();

      // random traffic on all channels
      do_reset();
      for (int c = 0; c < NUM_CH; c++) txq[c].delete();
      for (int cyc = 0; cyc < 4000; cyc++) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (txq[c].size() == 0) gen_frame(c);
            rx_done[c] = 1'($urandom_range(0, 1));
            if (rx_done[c]) rx_data[8*c +: 8] = txq[c].pop_front();
            else            rx_data[8*c +: 8] = 8'($urandom);
         end
         pkt_ready = 1'($urandom_range(0, 1));
         rd_addr   = LEN_W'($urandom_range(0, 7));
         step();
      end
      rx_done   = '0;
      pkt_ready = 1'b1;
      idle(30);
      chk("drain_valid", pkt_valid, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
